prescaled_down_timer: RTL
=========================

Name: prescaled_down_timer

Overview:
- Parametrised down-counting timer with integrated prescaler, start/stop control, one-shot or auto-reload mode, and a one-cycle terminal pulse.
- Used as a general-purpose timebase or event-delay generator.
- Successor to the single-width down counter. Adds configurable widths, an explicit run state, mode selection, abort, and a defined full-period formula.

Parameters:
- CNT_W, 16, width of main counter, reload value and count output.
- PSC_W, 5, width of prescale compare value and internal prescale counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low in RUN, prescaler and counter freeze.
- start  in  1  single-cycle request: load reload, clear prescaler, enter RUN.
- stop  in  1  single-cycle request: abort to IDLE, no done pulse.
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled live.
- psc  in  PSC_W  prescale compare; a tick occurs every psc+1 enabled cycles.
- reload  in  CNT_W  start/reload value; sampled on start and on each auto-reload.
- tick  out  1  one-cycle pulse on each prescaler terminal cycle while RUN.
- done  out  1  one-cycle pulse when the counter expires.
- busy  out  1  high in RUN.
- count  out  CNT_W  current counter value.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, count=0, prescale counter=0, tick=0, done=0, busy=0. Reset overrides start and stop in the same cycle.

IDLE:
- count holds its value; prescaler is held at 0; tick and done are 0.
- start=1: next cycle count=reload, prescaler=0, state=RUN, busy=1.

RUN with en=1:
- The prescaler increments each cycle.
- When prescaler >= psc: prescaler wraps to 0 and tick=1 in that cycle. The `>=` comparison covers psc lowered mid-count. With psc=0, tick fires every cycle.
- On a tick with count!=0: count <= count-1.
- On a tick with count==0: done=1 in the same cycle as tick.
  - mode=1: count <= reload (current input), stay in RUN.
  - mode=0: state <= IDLE, count stays 0, busy drops the next cycle.

RUN with en=0:
- Prescaler, count and state hold.
- tick=0 and done=0.
- start and stop are still honoured.

Timing and arithmetic:
- Period from start to the first done is (reload+1)*(psc+1) enabled cycles. With reload=0, done occurs on the first tick.
- tick and done are registered outputs. Counter width arithmetic is modulo 2^CNT_W.
- Underflow cannot occur: count==0 always reloads or stops, never decrements.

Priority in RUN (highest first):
- reset > start > stop > tick.
- start during RUN restarts: count=reload, prescaler=0, no done, even if a tick would have expired the counter that cycle.
- stop and start together: start wins.
- stop: state=IDLE, count holds its current value, no done.

Live inputs:
- mode is evaluated at the expiry tick.
- A change to reload mid-run takes effect only at the next start or auto-reload.

Test Plan:
- psc=0, reload=3, mode=0, en=1, pulse start → count steps 3,2,1,0. done high exactly 4 cycles after the start-cycle+1. busy falls the next cycle. count stays 0 in IDLE.
- psc=4, reload=2, mode=1, en held 1 → tick every 5 cycles. done every 15 cycles, repeated 3 times. count reloads to 2 after each done. busy stays 1.
- psc=1, reload=5, mode=0; drop en for 7 cycles mid-run → count and prescaler frozen during the gap. done delayed by exactly 7 cycles vs. the 12-cycle nominal.
- Auto-reload run; assert stop when count=1 → state IDLE, count holds 1, no done ever. A later start reloads the new reload=9 correctly.
- start asserted on the same cycle as the expiry tick (count=0, mode=1) → no done. count=reload, prescaler=0. Also assert start and stop together → restart wins.
- Assert reset mid-run with start=1 the same cycle → all outputs 0 and state IDLE next cycle. A start after reset deasserts behaves normally.

Source files
------------

// File: rtl/prescaled_down_timer.sv
// Down-counting timer with an integrated prescaler, start/stop control and
// one-shot or auto-reload operation; tick and done are registered one-cycle pulses.
module prescaled_down_timer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [PSC_W-1:0] psc,
  input  logic [CNT_W-1:0] reload,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PscOne = {{(PSC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PSC_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        pre_d = '0;
        if (start) begin
          state_d = StRun;
          count_d = reload;
        end
      end
      StRun: begin
        if (start) begin
          // Restart takes precedence even over an expiry in this cycle.
          count_d = reload;
          pre_d   = '0;
        end else if (stop) begin
          state_d = StIdle;
          pre_d   = '0;
        end else if (en) begin
          // >= rather than == so a psc lowered mid-count still wraps.
          if (pre_q >= psc) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (count_q == '0) begin
              done_d = 1'b1;
              if (mode) begin
                count_d = reload;
              end else begin
                state_d = StIdle;
              end
            end else begin
              count_d = count_q - CntOne;
            end
          end else begin
            pre_d = pre_q + PscOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tick  = tick_q;
  assign done  = done_q;
  assign busy  = (state_q == StRun);
  assign count = count_q;

endmodule
